// File: rtl/calc_sequencer.sv
// calc_sequencer: Moore FSM driving the 4-bit calculator's X/Y/Z register controls and ALU opcode.
// Optional feature macro CALC_SEQ_CHAIN_EN adds a WB state that copies Z back into X after ADD/SUB.
module calc_sequencer #(
  parameter int CW  = 4,
  parameter int SHW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd,
  input  logic [1:0]     op,
  input  logic [SHW-1:0] shamt,
  output logic [CW-1:0]  Tx,
  output logic [CW-1:0]  Ty,
  output logic [CW-1:0]  Tz,
  output logic [1:0]     alu_op,
  output logic           x_sel,
  output logic           busy,
  output logic           done
);

  typedef enum logic [3:0] {
    INIT, IDLE, LDX, LDY, CLR, ALU, STORE, SHIFT, WB, DONE
  } state_t;

  localparam logic [2:0] C_HOLD   = 3'b000;
  localparam logic [2:0] C_LOAD   = 3'b001;
  localparam logic [2:0] C_SHIFTR = 3'b010;
  localparam logic [2:0] C_SHIFTL = 3'b011;
  localparam logic [2:0] C_CLEAR  = 3'b100;

  localparam logic [1:0] CMD_LDX  = 2'b00;
  localparam logic [1:0] CMD_LDY  = 2'b01;
  localparam logic [1:0] CMD_EXEC = 2'b10;

  state_t         state, state_nxt;
  logic [SHW-1:0] cnt, cnt_nxt;
  logic [1:0]     op_q;
  logic [2:0]     tx_c, ty_c, tz_c;

  // The shift counter doubles as the latched shamt: it is loaded at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && cmd_valid) op_q <= op;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tx_c      = C_HOLD;
    ty_c      = C_HOLD;
    tz_c      = C_HOLD;
    alu_op    = 2'b00;
    x_sel     = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      INIT: begin
        tx_c      = C_CLEAR;
        ty_c      = C_CLEAR;
        tz_c      = C_CLEAR;
        state_nxt = IDLE;
      end
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          cnt_nxt = shamt;
          case (cmd)
            CMD_LDX:  state_nxt = LDX;
            CMD_LDY:  state_nxt = LDY;
            CMD_EXEC: begin
              if (!op[1])             state_nxt = ALU;
              else if (shamt == '0)   state_nxt = DONE;
              else                    state_nxt = SHIFT;
            end
            default:  state_nxt = CLR;
          endcase
        end
      end
      LDX: begin
        tx_c      = C_LOAD;
        state_nxt = DONE;
      end
      LDY: begin
        ty_c      = C_LOAD;
        state_nxt = DONE;
      end
      CLR: begin
        tx_c      = C_CLEAR;
        ty_c      = C_CLEAR;
        tz_c      = C_CLEAR;
        state_nxt = DONE;
      end
      // ALU gives the combinational result one cycle to settle before Z loads it.
      ALU: begin
        alu_op    = op_q;
        state_nxt = STORE;
      end
      STORE: begin
        alu_op = op_q;
        tz_c   = C_LOAD;
`ifdef CALC_SEQ_CHAIN_EN
        state_nxt = WB;
`else
        state_nxt = DONE;
`endif
      end
      SHIFT: begin
        tx_c    = op_q[0] ? C_SHIFTR : C_SHIFTL;
        cnt_nxt = cnt - 1'b1;
        if (cnt == SHW'(1)) state_nxt = DONE;
      end
`ifdef CALC_SEQ_CHAIN_EN
      WB: begin
        tx_c      = C_LOAD;
        x_sel     = 1'b1;
        state_nxt = DONE;
      end
`endif
      DONE: begin
        done      = 1'b1;
        busy      = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Tx = CW'(tx_c);
  assign Ty = CW'(ty_c);
  assign Tz = CW'(tz_c);

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: table-driven check of calc_sequencer against a small X/Y/Z/ALU datapath model.
// Build with +define+CALC_SEQ_CHAIN_EN to check the chained write-back variant.
module tb_calc_sequencer;

  localparam int CW  = 4;
  localparam int SHW = 2;

`ifdef CALC_SEQ_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  localparam logic [CW-1:0] T_HOLD = 4'b0000;
  localparam logic [CW-1:0] T_LOAD = 4'b0001;
  localparam logic [CW-1:0] T_SHR  = 4'b0010;
  localparam logic [CW-1:0] T_SHL  = 4'b0011;
  localparam logic [CW-1:0] T_CLR  = 4'b0100;

  localparam int LAT_ALU = CHAIN ? 4 : 3;
  localparam int WB_LD   = CHAIN ? 1 : 0;
  localparam logic [3:0] X_ADD = CHAIN ? 4'h8 : 4'h3;
  localparam logic [3:0] Z_SUB = CHAIN ? 4'h3 : 4'hE;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cmd_valid = 1'b0;
  logic [1:0]     cmd = 2'b00;
  logic [1:0]     op = 2'b00;
  logic [SHW-1:0] shamt = '0;
  logic           cmd_ready;
  logic [CW-1:0]  Tx, Ty, Tz;
  logic [1:0]     alu_op;
  logic           x_sel, busy, done;

  logic [3:0] bus = 4'h0;
  logic [3:0] x_reg, y_reg, z_reg, alu_res;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0] cmd;
    logic [1:0] op;
    logic [1:0] shamt;
    logic [3:0] bus;
    int         lat, tx_load, ty_load, tz_load, shl, shr, sub;
    logic [3:0] x, y, z;
  } vec_t;

  typedef struct {
    int lat, tx_load, ty_load, tz_load, shl, shr, sub, ready, busy;
    bit timeout;
  } obs_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  calc_sequencer #(.CW(CW), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .op(op), .shamt(shamt), .Tx(Tx), .Ty(Ty), .Tz(Tz),
    .alu_op(alu_op), .x_sel(x_sel), .busy(busy), .done(done)
  );

  // Datapath model: registers act on the control codes at the negedge of each cycle.
  always_comb alu_res = (alu_op == 2'b01) ? x_reg - y_reg : x_reg + y_reg;

  always @(negedge clk) begin
    case (Tx)
      T_LOAD:  x_reg <= x_sel ? z_reg : bus;
      T_SHR:   x_reg <= x_reg >> 1;
      T_SHL:   x_reg <= x_reg << 1;
      T_CLR:   x_reg <= 4'h0;
      default: ;
    endcase
    case (Ty)
      T_LOAD:  y_reg <= bus;
      T_CLR:   y_reg <= 4'h0;
      default: ;
    endcase
    case (Tz)
      T_LOAD:  z_reg <= alu_res;
      T_CLR:   z_reg <= 4'h0;
      default: ;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Waits (bounded) for cmd_ready, presents one command across the accepting edge.
  task automatic applyStimulus(input logic [1:0] c, input logic [1:0] o, input logic [1:0] s,
                               input logic [3:0] b, input bit hold_valid, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    cmd = c; op = o; shamt = s; bus = b;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold_valid) cmd_valid = 1'b0;
  endtask

  // Observes from the first post-acceptance cycle through the done cycle.
  task automatic collect(output obs_t ob);
    ob = '{default: 0};
    for (int k = 0; k < 40; k++) begin
      ob.lat++;
      if (Tx === T_LOAD) ob.tx_load++;
      if (Ty === T_LOAD) ob.ty_load++;
      if (Tz === T_LOAD) ob.tz_load++;
      if (Tx === T_SHL) ob.shl++;
      if (Tx === T_SHR) ob.shr++;
      if (alu_op === 2'b01) ob.sub++;
      if (cmd_ready !== 1'b0) ob.ready++;
      if (busy === 1'b1) ob.busy++;
      if (done === 1'b1) return;
      @(posedge clk); #1;
    end
    ob.timeout = 1'b1;
  endtask

  initial begin
    obs_t ob;
    bit   ok;
    int   cnt;

    vecs[0]  = '{2'b00, 2'b00, 2'd0, 4'h9, 2, 1, 0, 0, 0, 0, 0, 4'h9, 4'h0, 4'h0};
    vecs[1]  = '{2'b00, 2'b00, 2'd0, 4'h3, 2, 1, 0, 0, 0, 0, 0, 4'h3, 4'h0, 4'h0};
    vecs[2]  = '{2'b01, 2'b00, 2'd0, 4'h5, 2, 0, 1, 0, 0, 0, 0, 4'h3, 4'h5, 4'h0};
    vecs[3]  = '{2'b10, 2'b00, 2'd0, 4'h0, LAT_ALU, WB_LD, 0, 1, 0, 0, 0, X_ADD, 4'h5, 4'h8};
    vecs[4]  = '{2'b10, 2'b01, 2'd0, 4'h0, LAT_ALU, WB_LD, 0, 1, 0, 0, 2, 4'h3, 4'h5, Z_SUB};
    vecs[5]  = '{2'b00, 2'b00, 2'd0, 4'h1, 2, 1, 0, 0, 0, 0, 0, 4'h1, 4'h5, Z_SUB};
    vecs[6]  = '{2'b10, 2'b10, 2'd3, 4'h0, 4, 0, 0, 0, 3, 0, 0, 4'h8, 4'h5, Z_SUB};
    vecs[7]  = '{2'b10, 2'b10, 2'd0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 4'h8, 4'h5, Z_SUB};
    vecs[8]  = '{2'b10, 2'b11, 2'd2, 4'h0, 3, 0, 0, 0, 0, 2, 0, 4'h2, 4'h5, Z_SUB};
    vecs[9]  = '{2'b10, 2'b11, 2'd1, 4'h0, 2, 0, 0, 0, 0, 1, 0, 4'h1, 4'h5, Z_SUB};
    vecs[10] = '{2'b11, 2'b00, 2'd0, 4'h0, 2, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0};

    // Reset held for three cycles: all registers cleared, no handshake.
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("reset%0d codes", k), {Tx, Ty, Tz}, {T_CLR, T_CLR, T_CLR});
      checkOutput($sformatf("reset%0d ready/busy/done", k), {cmd_ready, busy, done}, 3'b010);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-reset ready/busy", {cmd_ready, busy}, 2'b10);
    checkOutput("post-reset xyz", {x_reg, y_reg, z_reg}, 12'h000);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].cmd, vecs[i].op, vecs[i].shamt, vecs[i].bus, 1'b0, ok);
      checkOutput($sformatf("v%0d ready wait", i), ok, 1);
      collect(ob);
      checkOutput($sformatf("v%0d timeout", i), ob.timeout, 0);
      checkOutput($sformatf("v%0d latency", i), ob.lat, vecs[i].lat);
      checkOutput($sformatf("v%0d Tx load cycles", i), ob.tx_load, vecs[i].tx_load);
      checkOutput($sformatf("v%0d Ty load cycles", i), ob.ty_load, vecs[i].ty_load);
      checkOutput($sformatf("v%0d Tz load cycles", i), ob.tz_load, vecs[i].tz_load);
      checkOutput($sformatf("v%0d SHL cycles", i), ob.shl, vecs[i].shl);
      checkOutput($sformatf("v%0d SHR cycles", i), ob.shr, vecs[i].shr);
      checkOutput($sformatf("v%0d SUB cycles", i), ob.sub, vecs[i].sub);
      checkOutput($sformatf("v%0d busy cycles", i), ob.busy, vecs[i].lat - 1);
      checkOutput($sformatf("v%0d ready while busy", i), ob.ready, 0);
      checkOutput($sformatf("v%0d X", i), x_reg, vecs[i].x);
      checkOutput($sformatf("v%0d Y", i), y_reg, vecs[i].y);
      checkOutput($sformatf("v%0d Z", i), z_reg, vecs[i].z);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d idle after done", i), {cmd_ready, done}, 2'b10);
    end

    // cmd_valid held through an EXEC: nothing else issued until the following IDLE.
    applyStimulus(2'b10, 2'b00, 2'd0, 4'h6, 1'b1, ok);
    cmd = 2'b01;
    collect(ob);
    checkOutput("held latency", ob.lat, LAT_ALU);
    checkOutput("held Ty load cycles", ob.ty_load, 0);
    checkOutput("held ready while busy", ob.ready, 0);
    @(posedge clk); #1;
    checkOutput("held idle", {cmd_ready, Ty}, {1'b1, T_HOLD});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("held next accepted", Ty, T_LOAD);
    collect(ob);
    checkOutput("held LDY latency", ob.lat, 2);
    checkOutput("held Y", y_reg, 4'h6);
    @(posedge clk); #1;

    // Reset in the second SHIFT cycle of a shamt=3 shift.
    applyStimulus(2'b00, 2'b00, 2'd0, 4'h1, 1'b0, ok);
    collect(ob);
    @(posedge clk); #1;
    applyStimulus(2'b10, 2'b10, 2'd3, 4'h0, 1'b0, ok);
    checkOutput("rst-shift cycle1", Tx, T_SHL);
    @(posedge clk); #1;
    checkOutput("rst-shift cycle2", Tx, T_SHL);
    rst = 1'b1;
    #1;
    checkOutput("rst-shift codes", {Tx, Ty, Tz}, {T_CLR, T_CLR, T_CLR});
    checkOutput("rst-shift ready/busy", {cmd_ready, busy}, 2'b01);
    cnt = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (Tx === T_SHL) cnt++;
    end
    checkOutput("rst-shift no SHL", cnt, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst-shift idle", {cmd_ready, busy}, 2'b10);
    checkOutput("rst-shift X cleared", x_reg, 4'h0);
    applyStimulus(2'b00, 2'b00, 2'd0, 4'hA, 1'b0, ok);
    collect(ob);
    checkOutput("rst-shift LDX latency", ob.lat, 2);
    checkOutput("rst-shift LDX X", x_reg, 4'hA);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Moore FSM that sequences the 4-bit calculator datapath: operand registers X and Y, result register Z, and the ALU.
- Accepts one command at a time over a valid/ready handshake.
- Emits per-register control codes (HOLD/LOAD/SHIFTR/SHIFTL/CLEAR) and the ALU opcode.
- Sits between the user/input front end and the register/ALU datapath.

Parameters:
- CW, 4, width of each register control code output; codes use bits [2:0], upper bits driven 0.
- SHW, 2, width of shift-amount field and internal shift counter.

Ports:
- clk  input  1  system clock; sequencer state updates on posedge, datapath registers sample on negedge of the same cycle.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd  input  2  00 LOAD_X, 01 LOAD_Y, 10 EXEC, 11 CLEAR_ALL.
- op  input  2  EXEC operation: 00 ADD, 01 SUB, 10 SHL, 11 SHR.
- shamt  input  SHW  shift count for SHL/SHR.
- Tx  output  CW  control code to register X.
- Ty  output  CW  control code to register Y.
- Tz  output  CW  control code to register Z.
- alu_op  output  2  ALU operation select (ADD=00, SUB=01).
- x_sel  output  1  X load source: 0 = data bus, 1 = Z.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Codes: HOLD=000, LOAD=001, SHIFTR=010, SHIFTL=011, CLEAR=100.
- All outputs are decoded from the state register only (Moore). Every code not listed below is HOLD. alu_op and x_sel default to 0.
- States: INIT, IDLE, LDX, LDY, CLR, ALU, STORE, SHIFT, WB, DONE.
- Reset (async, any time, including mid-command):
  - state=INIT, shift counter=0, latched op/shamt=0.
  - While in INIT: Tx=Ty=Tz=CLEAR, busy=1, cmd_ready=0, done=0.
- INIT -> IDLE on the first posedge after rst deasserts.
- IDLE:
  - cmd_ready=1, busy=0.
  - Command accepted on a posedge with cmd_valid=1; op and shamt are latched at acceptance.
  - Next state by cmd: LDX, LDY, ALU (EXEC with op ADD/SUB), SHIFT (EXEC with op SHL/SHR and shamt!=0), DONE (EXEC with op SHL/SHR and shamt=0), CLR.
- In every state other than IDLE: cmd_ready=0, busy=1 (DONE excepted, see below). cmd_valid is ignored; no queuing.
- LDX: Tx=LOAD, x_sel=0 -> DONE.
- LDY: Ty=LOAD -> DONE.
- CLR: Tx=Ty=Tz=CLEAR -> DONE.
- ALU:
  - alu_op=latched op, Tz=HOLD (one settle cycle) -> STORE.
  - STORE: Tz=LOAD, alu_op held -> WB if CHAIN_EN is defined, else DONE.
- SHIFT:
  - Counter loaded with shamt at acceptance.
  - Each SHIFT cycle: Tx=SHIFTL (SHL) or SHIFTR (SHR), counter decrements.
  - Exit to DONE in the cycle the counter equals 1. Exactly shamt shift cycles are issued; shamt=0 issues none.
- DONE: done=1, busy=0, cmd_ready=0 -> IDLE.
- Latency, acceptance edge to done-high cycle:
  - LOAD_X, LOAD_Y, CLEAR_ALL: 2 cycles.
  - ADD/SUB: 3 cycles (4 with CHAIN_EN).
  - SHL/SHR: shamt+1 cycles.
- Back-to-back commands: minimum spacing is one IDLE cycle after DONE.
- Unused state encodings recover to IDLE.

Optional Feature:
- Macro: CALC_SEQ_CHAIN_EN.
- Defined:
  - After STORE, WB state drives Tx=LOAD, x_sel=1 (result copied into X for chained operations) -> DONE.
- Undefined:
  - WB is unreachable and x_sel is tied 0.
  - STORE -> DONE directly.

Test Plan:
- Hold rst=1 for 3 cycles: Tx=Ty=Tz=100, cmd_ready=0. First posedge after release: IDLE with cmd_ready=1, X=Y=Z=0.
- cmd=00 valid: Tx=001 for exactly one cycle, then done=1 one cycle later. X captures bus value 4'h9.
- X=3, Y=5, cmd=10, op=00: alu_op=00 for 2 cycles, Tz=001 in the STORE cycle only, Z=8, done on cycle 3. With CALC_SEQ_CHAIN_EN: X=8 and done on cycle 4.
- X=4'b0001, cmd=10, op=10, shamt=3: exactly 3 cycles of Tx=011, X=4'b1000, done on cycle 4. Repeat with shamt=0: no shift code issued, done on cycle 1.
- Assert cmd_valid every cycle during an EXEC: cmd_ready stays 0 and no extra codes are issued. Next command is accepted only in IDLE.
- Assert rst during the 2nd SHIFT cycle of shamt=3: immediate INIT (codes=100), no further SHIFTL, clean return to IDLE after release.
